// File: rtl/monolith_arb_pkg.sv
// Shared types and default sizes for the monolith_hash arbiter.
// Word/state geometry matches the monolith_hash permutation engine.
package monolith_arb_pkg;

  localparam int WORD_WIDTH_DEF = 31;
  localparam int PERM_SIZE_DEF  = 16;

  typedef logic [WORD_WIDTH_DEF-1:0] word_t;
  typedef word_t perm_state_t [PERM_SIZE_DEF];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_RESPOND
  } arb_state_e;

endpackage

// File: rtl/monolith_hash_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr.
// Zero latency; produces a one-hot grant plus its encoded index.
module monolith_rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sum       = '0;
    pos       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (req_valid[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/monolith_hash_arbiter.sv
// Round-robin arbiter sharing one monolith_hash engine; accept -> LOAD -> COMPUTE -> RESPOND,
// result held until the granted requester's rsp_ready; watchdog forces an error response.
module monolith_hash_arbiter
  import monolith_arb_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  PERM_SIZE   = PERM_SIZE_DEF,
  parameter int  WORD_WIDTH  = WORD_WIDTH_DEF,
  parameter int  MAX_LATENCY = 64,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WD_W        = $clog2(MAX_LATENCY + 1)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ-1:0][PERM_SIZE-1:0][WORD_WIDTH-1:0] req_state,
  output logic [NUM_REQ-1:0]                           req_ready,
  output logic [NUM_REQ-1:0]                           rsp_valid,
  input  logic [NUM_REQ-1:0]                           rsp_ready,
  output logic [PERM_SIZE-1:0][WORD_WIDTH-1:0]         rsp_state,
  output logic                                         rsp_error,
  output logic                                         hash_rst,
  output logic [PERM_SIZE-1:0][WORD_WIDTH-1:0]         hash_state_in,
  input  logic [PERM_SIZE-1:0][WORD_WIDTH-1:0]         hash_state_out,
  input  logic                                         hash_valid,
  output logic                                         busy,
  output logic [IDX_W-1:0]                             grant_id,
  output logic                                         error
);

  arb_state_e                           state;
  logic [IDX_W-1:0]                     rr_ptr;
  logic [NUM_REQ-1:0]                   pick;
  logic [IDX_W-1:0]                     pick_idx;
  logic [WD_W-1:0]                      wdog;
  logic [WD_W-1:0]                      wd_inc;
  logic                                 timeout;
  logic [PERM_SIZE-1:0][WORD_WIDTH-1:0] in_reg;

  monolith_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick),
    .grant_idx (pick_idx)
  );

  assign req_ready     = (state == ST_IDLE && !reset) ? pick : '0;
  assign hash_state_in = in_reg;
  assign wd_inc        = (wdog == '1) ? wdog : wdog + 1'b1;
  assign timeout       = (wdog >= WD_W'(MAX_LATENCY));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      in_reg    <= '0;
      rsp_state <= '0;
      rsp_error <= 1'b0;
      rsp_valid <= '0;
      hash_rst  <= 1'b1;
      busy      <= 1'b0;
      grant_id  <= '0;
      error     <= 1'b0;
      wdog      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            in_reg   <= req_state[pick_idx];
            grant_id <= pick_idx;
            rr_ptr   <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            wdog     <= '0;
            hash_rst <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wdog  <= wd_inc;
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          wdog <= wd_inc;
          // A result landing on the expiry cycle takes priority over the timeout.
          if (hash_valid) begin
            rsp_state <= hash_state_out;
            rsp_error <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            hash_rst  <= 1'b1;
            state     <= ST_RESPOND;
          end else if (timeout) begin
            rsp_state <= '0;
            rsp_error <= 1'b1;
            error     <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            hash_rst  <= 1'b1;
            state     <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monolith_hash_arbiter.sv
// Scoreboard bench for monolith_hash_arbiter with a stub engine that adds 1 to every word.
module tb_monolith_hash_arbiter;
  import monolith_arb_pkg::*;

  localparam int NR   = 4;
  localparam int PS   = PERM_SIZE_DEF;
  localparam int WW   = WORD_WIDTH_DEF;
  localparam int MAXL = 12;
  localparam int SW   = PS * WW;

  typedef logic [PS-1:0][WW-1:0] st_t;
  typedef struct packed {
    logic [1:0]  id;
    logic        err;
    st_t         st;
    logic [31:0] acc;
    logic [31:0] lat;
  } sb_t;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NR-1:0]                 req_valid;
  logic [NR-1:0][PS-1:0][WW-1:0] req_state;
  logic [NR-1:0]                 req_ready;
  logic [NR-1:0]                 rsp_valid;
  logic [NR-1:0]                 rsp_ready;
  st_t                           rsp_state;
  logic                          rsp_error;
  logic                          hash_rst;
  st_t                           hash_state_in;
  st_t                           hash_state_out;
  logic                          hash_valid;
  logic                          busy;
  logic [1:0]                    grant_id;
  logic                          error;

  sb_t  sb_q[$];
  int   gnt_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_rsp   = 0;
  int   cyc     = 0;
  int   stub_cnt;
  int   stub_dly;
  logic stub_en;
  int   exp_lat;
  logic exp_err;
  logic [NR-1:0] prev_rsp_valid = '0;
  st_t  exp_bp;

  monolith_hash_arbiter #(
    .NUM_REQ(NR), .PERM_SIZE(PS), .WORD_WIDTH(WW), .MAX_LATENCY(MAXL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_state      (req_state),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_state      (rsp_state),
    .rsp_error      (rsp_error),
    .hash_rst       (hash_rst),
    .hash_state_in  (hash_state_in),
    .hash_state_out (hash_state_out),
    .hash_valid     (hash_valid),
    .busy           (busy),
    .grant_id       (grant_id),
    .error          (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub engine: done stub_dly cycles after hash_rst falls, result = input + 1 per word.
  always @(posedge clk) begin
    if (hash_rst) stub_cnt <= 0;
    else          stub_cnt <= stub_cnt + 1;
  end
  assign hash_valid = !hash_rst && stub_en && (stub_cnt == stub_dly);
  always_comb begin
    hash_state_out = '0;
    for (int k = 0; k < PS; k++) hash_state_out[k] = hash_state_in[k] + 1'b1;
  end

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_acc(input int n);
    int c = 0;
    while (n_acc < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk("accept_wait", n_acc, n);
  endtask

  task automatic wait_rsp(input int n);
    int c = 0;
    while (n_rsp < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk("response_wait", n_rsp, n);
  endtask

  // Monitor: push expectations on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    sb_t e;
    int  w;
    int  g;
    if (|(req_valid & req_ready)) begin
      w = 0;
      for (int i = 0; i < NR; i++) if (req_ready[i]) w = i;
      n_acc++;
      if (gnt_q.size() == 0) chk("grant_unexpected", req_ready, 0);
      else begin
        g = gnt_q.pop_front();
        chk("grant", req_ready, 4'(1) << g);
      end
      e.id  = 2'(w);
      e.err = exp_err;
      e.acc = cyc;
      e.lat = exp_lat;
      for (int k = 0; k < PS; k++) e.st[k] = exp_err ? '0 : req_state[w][k] + 1'b1;
      sb_q.push_back(e);
    end
    if (rsp_valid != '0 && prev_rsp_valid == '0) begin
      if (sb_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else chk("rsp_latency", cyc - sb_q[0].acc, sb_q[0].lat);
    end
    if (|(rsp_valid & rsp_ready)) begin
      if (sb_q.size() == 0) chk("rsp_unexpected_hs", rsp_valid, 0);
      else begin
        e = sb_q.pop_front();
        n_rsp++;
        chk("rsp_port",  rsp_valid, 4'(1) << e.id);
        chk("rsp_error", rsp_error, e.err);
        chk("rsp_state", rsp_state, e.st);
        chk("grant_id",  grant_id,  e.id);
      end
    end
    prev_rsp_valid = rsp_valid;
  end

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    stub_en   = 1'b1;
    stub_dly  = 10;
    exp_lat   = 12;
    exp_err   = 1'b0;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < PS; k++)
        req_state[i][k] = (i == 0) ? WW'(k) : WW'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_state", rsp_state, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_hash_rst",  hash_rst, 1);
    chk("rst_hash_in",   hash_state_in, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_grant_id",  grant_id, 0);
    chk("rst_error",     error, 0);

    // Contention: all four requesting, then only 1 and 3.
    @(posedge clk); #1;
    reset = 1'b0;
    for (int g = 0; g < NR; g++) gnt_q.push_back(g);
    wait_acc(4);
    req_valid = 4'b1010;
    gnt_q.push_back(1);
    gnt_q.push_back(3);
    wait_acc(6);
    req_valid = '0;
    wait_rsp(6);

    // Single request from port 0.
    gnt_q.push_back(0);
    req_valid = 4'b0001;
    wait_acc(7);
    req_valid = '0;
    wait_rsp(7);

    // Backpressure with other requesters waiting.
    rsp_ready = '0;
    for (int k = 0; k < PS; k++) exp_bp[k] = req_state[0][k] + 1'b1;
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    req_valid = 4'b0001;
    wait_acc(8);
    req_valid = 4'b1110;
    for (int c = 0; c < 40 && rsp_valid == '0; c++) @(negedge clk);
    chk("bp_rsp_seen", rsp_valid, 4'b0001);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 4'b0001);
      chk("bp_rsp_state", rsp_state, exp_bp);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_grant", req_ready, 4'b0010);
    wait_acc(9);
    req_valid = '0;
    wait_rsp(9);

    // Result arriving on the watchdog expiry cycle.
    stub_dly = MAXL;
    exp_lat  = MAXL + 2;
    gnt_q.push_back(2);
    req_valid = 4'b0100;
    wait_acc(10);
    req_valid = '0;
    wait_rsp(10);
    chk("race_error_flag", error, 0);

    // Engine never finishes.
    stub_en = 1'b0;
    exp_err = 1'b1;
    gnt_q.push_back(3);
    req_valid = 4'b1000;
    wait_acc(11);
    req_valid = '0;
    wait_rsp(11);
    chk("timeout_error_flag", error, 1);

    // Good transaction after a timeout keeps the sticky flag.
    stub_en  = 1'b1;
    stub_dly = 10;
    exp_lat  = 12;
    exp_err  = 1'b0;
    gnt_q.push_back(0);
    req_valid = 4'b0001;
    wait_acc(12);
    req_valid = '0;
    wait_rsp(12);
    chk("error_sticky", error, 1);

    // Reset three cycles after accept, while computing.
    gnt_q.push_back(2);
    req_valid = 4'b0100;
    wait_acc(13);
    req_valid = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_state", rsp_state, 0);
    chk("mid_rsp_error", rsp_error, 0);
    chk("mid_hash_rst",  hash_rst, 1);
    chk("mid_hash_in",   hash_state_in, 0);
    chk("mid_busy",      busy, 0);
    chk("mid_grant_id",  grant_id, 0);
    chk("mid_error",     error, 0);
    sb_q.delete();
    gnt_q.push_back(0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_acc(14);
    req_valid = '0;
    wait_rsp(13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
